// File: rtl/sr_latch_monitor_if.sv
// sr_latch_monitor_if
// Purpose : event handshake between the latch monitor (producer) and its
//           consumer.
// Signals : evt_valid - an event is pending (producer drives)
//           evt_code  - committed state carried by the event (producer drives)
//           evt_ready - consumer accepts the event (consumer drives)
interface sr_latch_monitor_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_code;

    modport master (output evt_valid, output evt_code, input evt_ready);
    modport slave  (input evt_valid, input evt_code, output evt_ready);
endinterface

// File: rtl/sr_latch_monitor.sv
// sr_latch_monitor
// Purpose : synchronizes and debounces the Q/Qbar outputs of an asynchronous
//           SR latch, tracks the committed latch state, reports every state
//           change as a valid/ready event, counts SET<->RESET toggles and
//           keeps sticky error flags.
// Ports   : clk          - single rising-edge clock
//           rst          - asynchronous active-high reset
//           q_in/qbar_in - raw asynchronous latch outputs
//           clr_flags    - clears invalid_flag and overrun_flag
//           evt          - event handshake (master side)
//           state        - current committed state
//           toggle_cnt   - saturating SET<->RESET transition count
//           invalid_flag - sticky, a commit to INVALID happened
//           overrun_flag - sticky, an event was dropped while one was pending
//
// state     | meaning
// ----------+-------------------------------------------
// UNKNOWN   | nothing committed since reset
// SET       | stable {q,qbar} = 10
// RESET     | stable {q,qbar} = 01
// INVALID   | stable {q,qbar} = 00 or 11
module sr_latch_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 q_in,
    input  logic                 qbar_in,
    input  logic                 clr_flags,
    sr_latch_monitor_if.master   evt,
    output logic [1:0]           state,
    output logic [CNT_W-1:0]     toggle_cnt,
    output logic                 invalid_flag,
    output logic                 overrun_flag
);

    typedef enum logic [1:0] {
        CLS_UNKNOWN = 2'b00,
        CLS_SET     = 2'b01,
        CLS_RESET   = 2'b10,
        CLS_INVALID = 2'b11
    } cls_t;

    localparam logic [7:0]       STABLE_C    = 8'(STABLE_CYCLES);
    localparam logic [7:0]       MATCH_ONE   = 8'd1;
    localparam logic [1:0]       FLUSH_EDGES = 2'd2;
    localparam logic [CNT_W-1:0] CNT_ONE     = 1;

    logic       q_s1, q_s2, qb_s1, qb_s2;
    logic [1:0] flush_cnt;
    cls_t       cand;
    logic [7:0] match_cnt;
    cls_t       state_r;
    cls_t       cls_now;
    logic       commit, new_evt, xfer, is_toggle;

    always_comb begin
        cls_now = CLS_INVALID;
        if (q_s2 && !qb_s2)
            cls_now = CLS_SET;
        else if (!q_s2 && qb_s2)
            cls_now = CLS_RESET;
    end

    // match_cnt stays 0 through the flush, so no commit can fire early.
    assign commit    = (match_cnt == STABLE_C);
    assign new_evt   = commit && (cand != state_r);
    assign xfer      = evt.evt_valid && evt.evt_ready;
    assign is_toggle = new_evt &&
                       (((state_r == CLS_SET)   && (cand == CLS_RESET)) ||
                        ((state_r == CLS_RESET) && (cand == CLS_SET)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_s1          <= 1'b0;
            q_s2          <= 1'b0;
            qb_s1         <= 1'b0;
            qb_s2         <= 1'b0;
            flush_cnt     <= 2'd0;
            cand          <= CLS_UNKNOWN;
            match_cnt     <= 8'd0;
            state_r       <= CLS_UNKNOWN;
            evt.evt_valid <= 1'b0;
            evt.evt_code  <= 2'b00;
            toggle_cnt    <= '0;
            invalid_flag  <= 1'b0;
            overrun_flag  <= 1'b0;
        end else begin
            q_s1  <= q_in;
            q_s2  <= q_s1;
            qb_s1 <= qbar_in;
            qb_s2 <= qb_s1;

            // The candidate starts as UNKNOWN, which no sample classifies as,
            // so the first post-flush sample always restarts the count at 1.
            if (flush_cnt != FLUSH_EDGES)
                flush_cnt <= flush_cnt + 2'd1;
            else if (cls_now != cand) begin
                cand      <= cls_now;
                match_cnt <= MATCH_ONE;
            end else if (match_cnt != STABLE_C)
                match_cnt <= match_cnt + MATCH_ONE;

            if (new_evt)
                state_r <= cand;

            if (is_toggle && (toggle_cnt != '1))
                toggle_cnt <= toggle_cnt + CNT_ONE;

            if (new_evt && (cand == CLS_INVALID))
                invalid_flag <= 1'b1;
            else if (clr_flags)
                invalid_flag <= 1'b0;

            if (new_evt && evt.evt_valid && !xfer)
                overrun_flag <= 1'b1;
            else if (clr_flags)
                overrun_flag <= 1'b0;

            // A transfer on the same edge frees the slot for the new event;
            // otherwise the pending code is kept and the new one is dropped.
            if (new_evt && (!evt.evt_valid || xfer)) begin
                evt.evt_valid <= 1'b1;
                evt.evt_code  <= cand;
            end else if (xfer)
                evt.evt_valid <= 1'b0;
        end
    end

    assign state = state_r;

endmodule

// File: tb/tb_sr_latch_monitor.sv
module tb_sr_latch_monitor;
    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       q_in = 1'b0;
    logic       qbar_in = 1'b0;
    logic       clr_flags = 1'b0;
    logic [1:0] state, state2;
    logic [7:0] toggle_cnt;
    logic [1:0] toggle_cnt2;
    logic       inv, ovr, inv2, ovr2;

    sr_latch_monitor_if evt_if();
    sr_latch_monitor_if evt_if2();

    sr_latch_monitor #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .q_in(q_in), .qbar_in(qbar_in), .clr_flags(clr_flags),
        .evt(evt_if), .state(state), .toggle_cnt(toggle_cnt),
        .invalid_flag(inv), .overrun_flag(ovr));

    sr_latch_monitor #(.STABLE_CYCLES(S), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .q_in(q_in), .qbar_in(qbar_in), .clr_flags(clr_flags),
        .evt(evt_if2), .state(state2), .toggle_cnt(toggle_cnt2),
        .invalid_flag(inv2), .overrun_flag(ovr2));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: history of classified input samples since reset
    // release; a commit at edge e happens when the S samples taken at edges
    // e-2-S .. e-3 (two synchronizer edges, one filter edge) all agree.
    logic [1:0] hist[$];
    int         ecount;
    logic [1:0] m_state, m_code;
    logic       m_valid, m_inv, m_ovr;
    int         m_tog, m_tog2;

    function automatic logic [1:0] cls(input logic q, input logic qb);
        if (q && !qb) return 2'b01;
        if (!q && qb) return 2'b10;
        return 2'b11;
    endfunction

    task automatic model_reset();
        hist.delete();
        ecount  = 0;
        m_state = 2'b00;
        m_code  = 2'b00;
        m_valid = 1'b0;
        m_inv   = 1'b0;
        m_ovr   = 1'b0;
        m_tog   = 0;
        m_tog2  = 0;
    endtask

    task automatic model_edge(input logic q, input logic qb, input logic rdy, input logic clr);
        logic [1:0] k;
        logic       commit, nev, xfer;
        ecount++;
        hist.push_back(cls(q, qb));
        commit = 1'b0;
        k = 2'b00;
        if (ecount >= S + 3) begin
            k = hist[ecount-3-S];
            commit = 1'b1;
            for (int i = ecount - 3 - S; i <= ecount - 4; i++)
                if (hist[i] != k) commit = 1'b0;
        end
        nev  = commit && (k != m_state);
        xfer = m_valid && rdy;
        if (nev && ((m_state == 2'b01 && k == 2'b10) || (m_state == 2'b10 && k == 2'b01))) begin
            if (m_tog < 255) m_tog++;
            if (m_tog2 < 3) m_tog2++;
        end
        if (nev && k == 2'b11) m_inv = 1'b1;
        else if (clr) m_inv = 1'b0;
        if (nev && m_valid && !xfer) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        if (nev && (!m_valid || xfer)) begin
            m_valid = 1'b1;
            m_code  = k;
        end else if (xfer) m_valid = 1'b0;
        if (nev) m_state = k;
    endtask

    task automatic step(input logic q, input logic qb, input logic rdy, input logic clr);
        q_in = q;
        qbar_in = qb;
        evt_if.evt_ready = rdy;
        evt_if2.evt_ready = rdy;
        clr_flags = clr;
        @(posedge clk);
        if (rst) model_reset();
        else model_edge(q, qb, rdy, clr);
        #1;
    endtask

    function automatic logic [23:0] got_vec();
        return {state, evt_if.evt_valid, evt_if.evt_code, toggle_cnt, inv, ovr,
                state2, evt_if2.evt_valid, evt_if2.evt_code, toggle_cnt2, inv2, ovr2};
    endfunction

    function automatic logic [23:0] exp_vec();
        return {m_state, m_valid, m_code, 8'(m_tog), m_inv, m_ovr,
                m_state, m_valid, m_code, 2'(m_tog2), m_inv, m_ovr};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b1);
            n_checks++;
            if (got_vec() !== 24'h0) begin
                n_fail++;
                $display("FAIL reset cycle %0d: got %h expected %h", i, got_vec(), 24'h0);
            end
        end
    endtask

    // Shared by power-on and post-reset recovery: releases rst and checks the
    // first commit lands exactly S+2 edges after the first sampling edge.
    task automatic test_power_on(input string tag);
        int commit_edge;
        commit_edge = -1;
        rst = 1'b0;
        model_reset();
        for (int e = 1; e <= 12; e++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL %s edge %0d: got %h expected %h", tag, e, got_vec(), exp_vec());
            end
            if (commit_edge < 0 && state == 2'b01) commit_edge = e;
        end
        n_checks++;
        if (commit_edge !== S + 3) begin
            n_fail++;
            $display("FAIL %s commit edge: got %0d expected %0d", tag, commit_edge, S + 3);
        end
        n_checks++;
        if ({evt_if.evt_valid, evt_if.evt_code, toggle_cnt} !== {1'b1, 2'b01, 8'd0}) begin
            n_fail++;
            $display("FAIL %s event: got valid=%b code=%b tog=%0d expected 1/01/0",
                     tag, evt_if.evt_valid, evt_if.evt_code, toggle_cnt);
        end
    endtask

    task automatic test_glitch();
        int events;
        logic [7:0] tog0;
        events = 0;
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        tog0 = toggle_cnt;
        for (int i = 0; i < 13; i++) begin
            if (i < 3) step(1'b0, 1'b1, 1'b1, 1'b0);
            else       step(1'b1, 1'b0, 1'b1, 1'b0);
            events += int'(evt_if.evt_valid);
            n_checks++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL glitch cycle %0d: got %h expected %h", i, got_vec(), exp_vec());
            end
        end
        n_checks++;
        if ({state, toggle_cnt, 8'(events)} !== {2'b01, tog0, 8'd0}) begin
            n_fail++;
            $display("FAIL glitch summary: got state=%b tog=%0d events=%0d expected 01/%0d/0",
                     state, toggle_cnt, events, tog0);
        end
    endtask

    task automatic test_toggle();
        int   events;
        logic prev_valid;
        events = 0;
        prev_valid = 1'b0;
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < 10; i++) begin
                if (t % 2 == 0) step(1'b0, 1'b1, 1'b1, 1'b0);
                else            step(1'b1, 1'b0, 1'b1, 1'b0);
                n_checks++;
                if (got_vec() !== exp_vec() || (prev_valid && evt_if.evt_valid)) begin
                    n_fail++;
                    $display("FAIL toggle %0d cycle %0d: got %h expected %h (prev_valid=%b)",
                             t, i, got_vec(), exp_vec(), prev_valid);
                end
                events += int'(evt_if.evt_valid);
                prev_valid = evt_if.evt_valid;
            end
        end
        n_checks++;
        if ({8'(events), toggle_cnt, toggle_cnt2} !== {8'd5, 8'd5, 2'd3}) begin
            n_fail++;
            $display("FAIL toggle summary: got events=%0d tog=%0d tog2=%0d expected 5/5/3",
                     events, toggle_cnt, toggle_cnt2);
        end
    endtask

    task automatic test_invalid();
        logic [7:0] tog0;
        logic [1:0] prev;
        int         hit;
        tog0 = toggle_cnt;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0);
            n_checks++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL invalid cycle %0d: got %h expected %h", i, got_vec(), exp_vec());
            end
        end
        n_checks++;
        if ({state, inv, toggle_cnt} !== {2'b11, 1'b1, tog0}) begin
            n_fail++;
            $display("FAIL invalid commit: got state=%b inv=%b tog=%0d expected 11/1/%0d",
                     state, inv, toggle_cnt, tog0);
        end
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (inv !== 1'b0) begin
            n_fail++;
            $display("FAIL invalid clear: got inv=%b expected 0", inv);
        end
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
        hit = 0;
        for (int i = 0; i < 10; i++) begin
            prev = m_state;
            step(1'b0, 1'b0, 1'b1, 1'b1);
            if (prev != 2'b11 && m_state == 2'b11) begin
                hit++;
                n_checks++;
                if (inv !== 1'b1) begin
                    n_fail++;
                    $display("FAIL invalid set-vs-clear: got inv=%b expected 1", inv);
                end
            end
            n_checks++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL invalid clr cycle %0d: got %h expected %h", i, got_vec(), exp_vec());
            end
        end
        n_checks++;
        if (hit !== 1) begin
            n_fail++;
            $display("FAIL invalid recommit count: got %0d expected 1", hit);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if (i < 10) step(1'b1, 1'b0, 1'b0, 1'b0);
            else        step(1'b0, 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL backpressure cycle %0d: got %h expected %h", i, got_vec(), exp_vec());
            end
        end
        n_checks++;
        if ({evt_if.evt_valid, evt_if.evt_code, ovr, state} !== {1'b1, 2'b01, 1'b1, 2'b10}) begin
            n_fail++;
            $display("FAIL backpressure result: got valid=%b code=%b ovr=%b state=%b expected 1/01/1/10",
                     evt_if.evt_valid, evt_if.evt_code, ovr, state);
        end
    endtask

    // Pending 01 event is still held; ready rises only on the edge that commits INVALID.
    task automatic test_ready_same_edge();
        step(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= S + 3; i++) begin
            step(1'b1, 1'b1, (i == S + 3), 1'b0);
            n_checks++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL same-edge cycle %0d: got %h expected %h", i, got_vec(), exp_vec());
            end
            if (i == S + 2) begin
                n_checks++;
                if ({state, evt_if.evt_valid, evt_if.evt_code} !== {2'b10, 1'b1, 2'b01}) begin
                    n_fail++;
                    $display("FAIL same-edge before: got state=%b valid=%b code=%b expected 10/1/01",
                             state, evt_if.evt_valid, evt_if.evt_code);
                end
            end
        end
        n_checks++;
        if ({state, evt_if.evt_valid, evt_if.evt_code, ovr} !== {2'b11, 1'b1, 2'b11, 1'b0}) begin
            n_fail++;
            $display("FAIL same-edge after: got state=%b valid=%b code=%b ovr=%b expected 11/1/11/0",
                     state, evt_if.evt_valid, evt_if.evt_code, ovr);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (evt_if.evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL same-edge drain: got valid=%b expected 0", evt_if.evt_valid);
        end
    endtask

    task automatic test_random();
        logic [1:0] pat;
        int         len;
        for (int blk = 0; blk < 80; blk++) begin
            pat = 2'($urandom_range(0, 3));
            len = $urandom_range(1, S + 4);
            for (int i = 0; i < len; i++) begin
                step(pat[1], pat[0], 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
                n_checks++;
                if (got_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL random blk %0d cycle %0d: got %h expected %h",
                             blk, i, got_vec(), exp_vec());
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (evt_if.evt_valid !== 1'b1 || got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset-mid setup: got %h expected %h", got_vec(), exp_vec());
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (got_vec() !== 24'h0) begin
            n_fail++;
            $display("FAIL reset-mid async: got %h expected %h", got_vec(), 24'h0);
        end
        @(posedge clk);
        #1;
        test_power_on("reset-mid recovery");
    endtask

    initial begin
        evt_if.evt_ready = 1'b0;
        evt_if2.evt_ready = 1'b0;
        test_reset();
        test_power_on("power-on");
        test_glitch();
        test_toggle();
        test_invalid();
        test_backpressure();
        test_ready_same_edge();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
